// File: rtl/pwm_audio_player_if.sv
// Avalon-MM read master bundle for the PWM audio player.
// Address width follows the player's ADDR_W.
interface pwm_audio_player_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] avm_m0_address;
  logic              avm_m0_read;
  logic              avm_m0_waitrequest;
  logic [31:0]       avm_m0_readdata;
  logic              avm_m0_readdatavalid;

  modport master (
    output avm_m0_address,
    output avm_m0_read,
    input  avm_m0_waitrequest,
    input  avm_m0_readdata,
    input  avm_m0_readdatavalid
  );

  modport slave (
    input  avm_m0_address,
    input  avm_m0_read,
    output avm_m0_waitrequest,
    output avm_m0_readdata,
    output avm_m0_readdatavalid
  );
endinterface

// File: rtl/pwm_audio_player.sv
// Playback engine: fetches packed 8-bit samples over Avalon-MM,
// scales by volume and drives a glitch-free 8-bit PWM output.
module pwm_audio_player #(
  parameter int SAMPLE_DIV = 6250,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] startaddr,
  input  logic [ADDR_W-1:0] stopaddr,
  input  logic [3:0]        volume,
  input  logic              start,
  input  logic              stop,
  pwm_audio_player_if.master avm,
  output logic              pwm_out,
  output logic              busy,
  output logic              irq
);

  localparam int TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, RUN, DRAIN
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] addr, end_addr;
  logic [TW-1:0]     tcnt;
  logic [3:0]        vol_q;
  logic [31:0]       pf_data, cur_data;
  logic              pf_full;
  logic [1:0]        cur_left;
  logic [7:0]        s_q, cur_byte;
  logic [7:0]        pwm_cnt, duty, target_duty;

  logic tick, playing, abort, accept, empty_go;
  logic fetch_done, finish, fill, take, rdv;

  assign rdv     = avm.avm_m0_readdatavalid;
  assign tick    = (tcnt == TW'(SAMPLE_DIV - 1));
  assign playing = (state == REQ) || (state == WAIT)
                || (state == RUN);
  assign abort   = stop && playing;
  assign accept  = (state == IDLE) && start && !stop;
  assign empty_go = accept && (startaddr >= stopaddr);

  assign fetch_done = (state == RUN) && !pf_full
                   && (addr >= end_addr);
  assign take   = tick && playing && !abort;
  assign finish = take && (cur_left == 2'd0)
               && !pf_full && fetch_done;
  assign fill   = (state == WAIT) && rdv && !abort;

  assign busy = (state != IDLE);
  assign avm.avm_m0_read    = (state == REQ);
  assign avm.avm_m0_address = addr;

  assign target_duty = 8'((12'(s_q) * 12'(vol_q)) >> 4);

  // cur_left counts bytes still to play; byte 0 is taken on load
  always_comb begin
    cur_byte = cur_data[15:8];
    case (cur_left)
      2'd2:    cur_byte = cur_data[23:16];
      2'd1:    cur_byte = cur_data[31:24];
      default: cur_byte = cur_data[15:8];
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:
        if (accept && !empty_go) state_d = REQ;
      REQ:
        if (abort)
          state_d = avm.avm_m0_waitrequest ? IDLE : DRAIN;
        else if (!avm.avm_m0_waitrequest)
          state_d = WAIT;
      WAIT:
        if (abort)     state_d = rdv ? IDLE : DRAIN;
        else if (rdv)  state_d = RUN;
      RUN:
        if (abort || finish)
          state_d = IDLE;
        else if (!pf_full && (addr < end_addr))
          state_d = REQ;
      DRAIN:
        if (rdv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      end_addr <= '0;
      tcnt     <= '0;
      vol_q    <= '0;
      pf_data  <= '0;
      pf_full  <= 1'b0;
      cur_data <= '0;
      cur_left <= '0;
      s_q      <= '0;
      pwm_cnt  <= '0;
      duty     <= '0;
      pwm_out  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      irq     <= finish || empty_go;
      tcnt    <= (accept || tick) ? '0 : tcnt + TW'(1);

      if (accept) begin
        addr     <= startaddr;
        end_addr <= stopaddr;
        vol_q    <= volume;
      end else if (tick) begin
        vol_q <= volume;
      end

      if (fill) begin
        pf_data <= avm.avm_m0_readdata;
        pf_full <= 1'b1;
        addr    <= addr + ADDR_W'(4);
      end

      // an empty-handed tick with fetch pending just holds the old sample
      if (take) begin
        if (cur_left != 2'd0) begin
          s_q      <= cur_byte;
          cur_left <= cur_left - 2'd1;
        end else if (pf_full) begin
          cur_data <= pf_data;
          cur_left <= 2'd3;
          pf_full  <= 1'b0;
          s_q      <= pf_data[7:0];
        end
      end

      if (pwm_cnt == 8'hFF && playing) duty <= target_duty;
      pwm_out <= busy && (pwm_cnt < duty);

      if (accept || abort || finish) begin
        pf_full  <= 1'b0;
        cur_left <= '0;
        s_q      <= '0;
        duty     <= '0;
        pwm_out  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_audio_player.sv
// Directed bench for pwm_audio_player with a small Avalon memory model.
// Runs with SAMPLE_DIV=16 so a sample tick lands every 16 clocks.
module tb_pwm_audio_player;

  localparam int SD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] startaddr, stopaddr;
  logic [3:0]  volume;
  logic        start, stop;
  logic        pwm_out, busy, irq;

  pwm_audio_player_if #(.ADDR_W(32)) bus ();

  pwm_audio_player #(
    .SAMPLE_DIV(SD),
    .ADDR_W(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .startaddr (startaddr),
    .stopaddr  (stopaddr),
    .volume    (volume),
    .start     (start),
    .stop      (stop),
    .avm       (bus.master),
    .pwm_out   (pwm_out),
    .busy      (busy),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      word;
    logic [3:0]       vol;
    logic [3:0][7:0]  exp;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] mem[256];
  logic [31:0] slow_addr = 32'hFFFF_FFF0;
  int          slow_extra = 0;
  logic [31:0] rd_log[$];
  int          checks = 0;
  int          errors = 0;
  int          irq_cnt = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(logic [31:0] sa, logic [31:0] ea,
                          logic [3:0] v);
    @(negedge clk);
    startaddr = sa;
    stopaddr  = ea;
    volume    = v;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic tick_wait();
    repeat (SD) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string name, int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  // Avalon slave: one read at a time, optional extra latency
  initial begin
    logic [31:0] a;
    bus.avm_m0_waitrequest   = 1'b0;
    bus.avm_m0_readdatavalid = 1'b0;
    bus.avm_m0_readdata      = '0;
    forever begin
      @(negedge clk);
      bus.avm_m0_readdatavalid = 1'b0;
      if (!rst && bus.avm_m0_read && !bus.avm_m0_waitrequest) begin
        a = bus.avm_m0_address;
        rd_log.push_back(a);
        if (a == slow_addr) repeat (slow_extra) @(negedge clk);
        @(negedge clk);
        bus.avm_m0_readdatavalid = 1'b1;
        bus.avm_m0_readdata      = mem[a[9:2]];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (irq) irq_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int i0, hi;
    vecs[0] = '{32'h04030201, 4'd15, {8'd3, 8'd2, 8'd1, 8'd0}};
    vecs[1] = '{32'hFF804000, 4'd15, {8'hEF, 8'h78, 8'h3C, 8'h00}};
    vecs[2] = '{32'hFF804000, 4'd0,  {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[3] = '{32'h10FF8001, 4'd8,  {8'd8, 8'h7F, 8'h40, 8'd0}};
    vecs[4] = '{32'hC8643219, 4'd1,  {8'd12, 8'd6, 8'd3, 8'd1}};
    vecs[5] = '{32'h01FEAA55, 4'd7,  {8'd0, 8'd111, 8'd74, 8'd37}};

    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hFFFF_FFFF;
    mem[8'h40] = 32'h04030201;
    mem[8'h41] = 32'h08070605;

    rst = 1'b1;
    startaddr = '0; stopaddr = '0; volume = '0;
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_read", 32'(bus.avm_m0_read), 0);
    chk("rst_addr", bus.avm_m0_address, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // two-word playback at volume 15
    rd_log.delete();
    i0 = irq_cnt;
    do_start(32'h100, 32'h108, 4'd15);
    for (int k = 0; k < 8; k++) begin
      tick_wait();
      chk($sformatf("main_duty%0d", k), 32'(dut.target_duty), k);
      chk($sformatf("main_busy%0d", k), 32'(busy), 1);
    end
    chk("main_noirq", 32'(irq), 0);
    tick_wait();
    chk("main_irq", 32'(irq), 1);
    chk("main_busy_end", 32'(busy), 0);
    @(posedge clk); #1;
    chk("main_irq_1cyc", 32'(irq), 0);
    chk("main_irq_cnt", irq_cnt - i0, 1);
    chk("main_nreads", rd_log.size(), 2);
    chk("main_rd0", rd_log[0], 32'h100);
    chk("main_rd1", rd_log[1], 32'h104);

    // one-word vectors at assorted volumes
    for (int v = 0; v < 6; v++) begin
      mem[8'hC0] = vecs[v].word;
      do_start(32'h300, 32'h304, vecs[v].vol);
      for (int k = 0; k < 4; k++) begin
        tick_wait();
        chk($sformatf("vec%0d_s%0d", v, k),
            32'(dut.target_duty), 32'(vecs[v].exp[k]));
      end
      tick_wait();
      chk($sformatf("vec%0d_irq", v), 32'(irq), 1);
      chk($sformatf("vec%0d_idle", v), 32'(busy), 0);
      repeat (2) @(negedge clk);
    end

    // empty and reversed ranges
    rd_log.delete();
    do_start(32'h200, 32'h200, 4'd15);
    chk("empty_irq", 32'(irq), 1);
    chk("empty_busy", 32'(busy), 0);
    @(negedge clk);
    chk("empty_irq_1cyc", 32'(irq), 0);
    do_start(32'h208, 32'h200, 4'd15);
    chk("rev_irq", 32'(irq), 1);
    chk("rev_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);
    chk("empty_noread", rd_log.size(), 0);

    // start together with stop is dropped
    i0 = irq_cnt;
    @(negedge clk);
    startaddr = 32'h100; stopaddr = 32'h108;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("ss_busy", 32'(busy), 0);
    chk("ss_noread", rd_log.size(), 0);
    chk("ss_noirq", irq_cnt - i0, 0);

    // waitrequest stall for five cycles
    bus.avm_m0_waitrequest = 1'b1;
    do_start(32'h100, 32'h104, 4'd15);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("wr_read%0d", c), 32'(bus.avm_m0_read), 1);
      chk($sformatf("wr_addr%0d", c), bus.avm_m0_address, 32'h100);
      if (c < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.avm_m0_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wr_released", 32'(bus.avm_m0_read), 0);
    chk("wr_nreads", rd_log.size(), 1);
    wait_idle("wr_done", 200);

    // second word late: tick coincides with the fill and underruns
    rd_log.delete();
    i0 = irq_cnt;
    slow_addr = 32'h104;
    slow_extra = 109;
    do_start(32'h100, 32'h108, 4'd15);
    for (int k = 0; k < 4; k++) begin
      tick_wait();
      chk($sformatf("late_s%0d", k), 32'(dut.target_duty), k);
    end
    for (int k = 0; k < 4; k++) begin
      tick_wait();
      chk($sformatf("late_hold%0d", k), 32'(dut.target_duty), 3);
      chk($sformatf("late_busy%0d", k), 32'(busy), 1);
    end
    for (int k = 4; k < 8; k++) begin
      tick_wait();
      chk($sformatf("late_s%0d", k), 32'(dut.target_duty), k);
    end
    chk("late_noirq", irq_cnt - i0, 0);
    tick_wait();
    chk("late_irq", 32'(irq), 1);
    chk("late_nreads", rd_log.size(), 2);
    slow_addr = 32'hFFFF_FFF0;
    repeat (2) @(negedge clk);

    // stop while the read is outstanding
    rd_log.delete();
    i0 = irq_cnt;
    slow_addr = 32'h100;
    slow_extra = 20;
    do_start(32'h100, 32'h108, 4'd15);
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (15) @(negedge clk);
    chk("stop_drain_busy", 32'(busy), 1);
    @(negedge clk);
    chk("stop_idle", 32'(busy), 0);
    chk("stop_pwm", 32'(pwm_out), 0);
    repeat (40) @(negedge clk);
    chk("stop_noirq", irq_cnt - i0, 0);
    chk("stop_nreads", rd_log.size(), 1);
    slow_addr = 32'hFFFF_FFF0;

    // full-scale samples: duty 127, then volume drop to 63
    do_start(32'h0, 32'h80, 4'd8);
    repeat (400) @(negedge clk);
    hi = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      hi += int'(pwm_out);
    end
    chk("pwm_hi127", hi, 127);
    volume = 4'd4;
    repeat (4) @(negedge clk);
    chk("vol_pending", 32'(dut.target_duty), 127);
    repeat (13) @(negedge clk);
    chk("vol_applied", 32'(dut.target_duty), 63);
    repeat (327) @(negedge clk);
    hi = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      hi += int'(pwm_out);
    end
    chk("pwm_hi63", hi, 63);

    // asynchronous reset in the middle of playback
    chk("pre_rst_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pwm", 32'(pwm_out), 0);
    chk("arst_irq", 32'(irq), 0);
    chk("arst_read", 32'(bus.avm_m0_read), 0);
    chk("arst_addr", bus.avm_m0_address, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
